// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares the single-port data RAM between the processor bus (master 0) and
//   a secondary master such as DMA or video fetch (master 1). Grants at most
//   one access per cycle and returns load data to the issuing master RD_LAT
//   cycles later. Master 0 has priority, a starvation counter bounds master
//   1's wait, and m0_lock keeps the bus on master 0 for read-modify-write.
//
// Ports
//   clock, reset              : clock; asynchronous active-low reset
//   mX_req/addr/read_type     : master X request, byte address, size/sign code
//   mX_write_data/write_en    : master X store data, 1 = store / 0 = load
//   m0_lock                   : keep the bus on master 0 after this access
//   mX_gnt                    : combinational grant
//   mX_rvalid/rdata           : load data return (rdata = memory_read_data)
//   memory_*                  : RAM-side request mux and RAM load data
// -----------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_req,
    input  logic [31:0] m0_addr,
    input  logic [2:0]  m0_read_type,
    input  logic [31:0] m0_write_data,
    input  logic        m0_write_en,
    input  logic        m0_lock,
    input  logic        m1_req,
    input  logic [31:0] m1_addr,
    input  logic [2:0]  m1_read_type,
    input  logic [31:0] m1_write_data,
    input  logic        m1_write_en,
    output logic        m0_gnt,
    output logic        m1_gnt,
    output logic        m0_rvalid,
    output logic        m1_rvalid,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic [31:0] memory_addr,
    output logic [2:0]  memory_read_type,
    output logic [31:0] memory_write_data,
    output logic        memory_write_en,
    input  logic [31:0] memory_read_data
);

    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {
        ST_ARB,
        ST_LOCK0
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_nxt;
    logic               w_starved;
    logic               w_m0_gnt;
    logic               w_m1_gnt;
    logic               w_load;

    // Read-return pipeline: valid bit and issuing master (1 = master 1)
    logic [RD_LAT-1:0]  r_vld;
    logic [RD_LAT-1:0]  r_id;

    assign w_starved = (r_wait_cnt == CNT_W'(STARVE_MAX));

    // Grant and next-state logic. A LOCK0 cycle with m0_req low releases the
    // lock at once and arbitrates as ARB, so master 1 can take that cycle.
    always_comb begin
        w_m0_gnt    = 1'b0;
        w_m1_gnt    = 1'b0;
        w_state_nxt = r_state;
        if (reset) begin
            if (r_state == ST_LOCK0 && m0_req) begin
                w_m0_gnt = 1'b1;
                if (!m0_lock)
                    w_state_nxt = ST_ARB;
            end else begin
                w_m1_gnt    = m1_req & (~m0_req | w_starved);
                w_m0_gnt    = m0_req & ~w_m1_gnt;
                w_state_nxt = (w_m0_gnt && m0_lock) ? ST_LOCK0 : ST_ARB;
            end
        end
    end

    always_comb begin
        w_wait_nxt = r_wait_cnt;
        if (!m1_req || w_m1_gnt)
            w_wait_nxt = '0;
        else if (!w_starved)
            w_wait_nxt = r_wait_cnt + CNT_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_ARB;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // RAM-side request mux; grants already imply the matching request
    always_comb begin
        memory_addr       = '0;
        memory_read_type  = '0;
        memory_write_data = '0;
        memory_write_en   = 1'b0;
        if (w_m0_gnt) begin
            memory_addr       = m0_addr;
            memory_read_type  = m0_read_type;
            memory_write_data = m0_write_data;
            memory_write_en   = m0_write_en;
        end else if (w_m1_gnt) begin
            memory_addr       = m1_addr;
            memory_read_type  = m1_read_type;
            memory_write_data = m1_write_data;
            memory_write_en   = m1_write_en;
        end
    end

    assign w_load = (w_m0_gnt & ~m0_write_en) | (w_m1_gnt & ~m1_write_en);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_vld <= '0;
            r_id  <= '0;
        end else begin
            r_vld[0] <= w_load;
            r_id[0]  <= w_m1_gnt;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_id[i]  <= r_id[i-1];
            end
        end
    end

    assign m0_gnt    = w_m0_gnt;
    assign m1_gnt    = w_m1_gnt;
    assign m0_rvalid = r_vld[RD_LAT-1] & ~r_id[RD_LAT-1];
    assign m1_rvalid = r_vld[RD_LAT-1] &  r_id[RD_LAT-1];
    assign m0_rdata  = memory_read_data;
    assign m1_rdata  = memory_read_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Drives dmem_arbiter with directed scenarios followed by random traffic.
//   A RAM model hangs off the memory_* port; a separate reference model
//   (integer starvation count, lock flag, shadow memory and a queue of
//   pending load returns) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int unsigned RD_LAT     = 2;
    localparam int unsigned STARVE_MAX = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0, m0_lock = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [2:0]  m0_read_type = '0, m1_read_type = '0;
    logic [31:0] m0_write_data = '0, m1_write_data = '0;
    logic        m0_write_en = 1'b0, m1_write_en = 1'b0;
    logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] memory_addr, memory_write_data, memory_read_data;
    logic [2:0]  memory_read_type;
    logic        memory_write_en;

    dmem_arbiter #(
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .m0_req            (m0_req),
        .m0_addr           (m0_addr),
        .m0_read_type      (m0_read_type),
        .m0_write_data     (m0_write_data),
        .m0_write_en       (m0_write_en),
        .m0_lock           (m0_lock),
        .m1_req            (m1_req),
        .m1_addr           (m1_addr),
        .m1_read_type      (m1_read_type),
        .m1_write_data     (m1_write_data),
        .m1_write_en       (m1_write_en),
        .m0_gnt            (m0_gnt),
        .m1_gnt            (m1_gnt),
        .m0_rvalid         (m0_rvalid),
        .m1_rvalid         (m1_rvalid),
        .m0_rdata          (m0_rdata),
        .m1_rdata          (m1_rdata),
        .memory_addr       (memory_addr),
        .memory_read_type  (memory_read_type),
        .memory_write_data (memory_write_data),
        .memory_write_en   (memory_write_en),
        .memory_read_data  (memory_read_data)
    );

    always #5 clock = ~clock;

    // ---------------- RAM model (fixed read latency RD_LAT) ----------------
    logic [31:0] ram     [0:255];
    logic [31:0] rd_pipe [0:RD_LAT-1];

    always @(posedge clock) begin
        if (memory_write_en)
            ram[memory_addr[9:2]] <= memory_write_data;
        rd_pipe[0] <= ram[memory_addr[9:2]];
        for (int i = 1; i < RD_LAT; i++)
            rd_pipe[i] <= rd_pipe[i-1];
    end
    assign memory_read_data = rd_pipe[RD_LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } ret_t;

    logic [31:0] ref_mem [0:255];
    ret_t        exp_q[$];
    int          m_wait   = 0;
    bit          m_locked = 1'b0;
    int          cyc      = 0;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // Evaluate one cycle at the falling edge: predict, compare, advance model.
    task automatic eval_cycle();
        bit          g0, g1, ewe, erv0, erv1;
        logic [31:0] ea, ewd, erd;
        logic [2:0]  ert;
        ret_t        r;
        cyc++;
        g0 = 0; g1 = 0; ewe = 0; erv0 = 0; erv1 = 0;
        ea = '0; ewd = '0; ert = '0; erd = '0;
        if (!reset) begin
            exp_q.delete();
            m_wait   = 0;
            m_locked = 1'b0;
        end else begin
            if (m_locked && m0_req) begin
                g0 = 1;
            end else begin
                g1 = m1_req && (!m0_req || m_wait == STARVE_MAX);
                g0 = m0_req && !g1;
            end
            if (g0) begin
                ea = m0_addr; ert = m0_read_type; ewd = m0_write_data; ewe = m0_write_en;
            end else if (g1) begin
                ea = m1_addr; ert = m1_read_type; ewd = m1_write_data; ewe = m1_write_en;
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                r    = exp_q.pop_front();
                erv0 = !r.id;
                erv1 = r.id;
                erd  = r.data;
            end
            if ((g0 || g1) && !ewe) begin
                r.due  = cyc + RD_LAT;
                r.id   = g1;
                r.data = ref_mem[ea[9:2]];
                exp_q.push_back(r);
            end
        end
        check_eq("m0_gnt", 32'(m0_gnt), 32'(g0));
        check_eq("m1_gnt", 32'(m1_gnt), 32'(g1));
        check_eq("mem_we", 32'(memory_write_en), 32'(ewe));
        check_eq("mem_addr", memory_addr, ea);
        check_eq("mem_wdata", memory_write_data, ewd);
        check_eq("mem_rtype", 32'(memory_read_type), 32'(ert));
        check_eq("m0_rvalid", 32'(m0_rvalid), 32'(erv0));
        check_eq("m1_rvalid", 32'(m1_rvalid), 32'(erv1));
        if (erv0) check_eq("m0_rdata", m0_rdata, erd);
        if (erv1) check_eq("m1_rdata", m1_rdata, erd);
        if (reset) begin
            if ((g0 || g1) && ewe)
                ref_mem[ea[9:2]] = ewd;
            m_locked = g0 && m0_lock;
            if (!m1_req || g1)
                m_wait = 0;
            else if (m_wait < STARVE_MAX)
                m_wait = m_wait + 1;
        end
    endtask

    // Inputs are applied #1 after a rising edge; checks happen at the falling edge.
    task automatic step();
        @(negedge clock);
        eval_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit r0, input int a0, input bit we0, input bit lk,
                         input bit r1, input int a1, input bit we1);
        logic [31:0] w;
        m0_req = r0; m0_addr = 32'(a0); m0_write_en = we0; m0_lock = lk;
        m1_req = r1; m1_addr = 32'(a1); m1_write_en = we1;
        w = $urandom; m0_write_data = w;
        w = $urandom; m1_write_data = w;
        w = $urandom; m0_read_type = w[2:0]; m1_read_type = w[5:3];
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (n) step();
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            ram[i]     = w;
            ref_mem[i] = w;
        end
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = '0;

        // Held in reset with both masters requesting: everything quiet
        @(posedge clock); #1;
        drive(1, 'h10, 1, 0, 1, 'h20, 1);
        repeat (2) step();
        reset = 1'b1;
        idle(2);

        // Master 0 load 0x100 then store 0x104
        drive(1, 'h100, 0, 0, 0, 0, 0); step();
        drive(1, 'h104, 1, 0, 0, 0, 0); step();
        idle(4);

        // Both masters continuously: 8 x m0 then 1 x m1, repeating
        for (int i = 0; i < 27; i++) begin
            drive(1, 4 * (i % 64), i % 3 == 0, 0, 1, 4 * ((i + 7) % 64), i % 4 == 0);
            step();
        end
        idle(3);

        // Long lock while master 1 saturates, then unlocking access
        for (int i = 0; i < 12; i++) begin
            drive(1, 'h200 + 4 * i, i % 2, 1, 1, 'h300, 0);
            step();
        end
        drive(1, 'h240, 1, 0, 1, 'h300, 0); step();
        drive(0, 0, 0, 0, 1, 'h300, 0);     step();
        idle(3);

        // Alternating loads m0, m1, m0 back to back
        drive(1, 'h40, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 'h44, 0); step();
        drive(1, 'h48, 0, 0, 0, 0, 0); step();
        idle(4);

        // Reset pulse with two loads in flight
        drive(1, 'h50, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 0, 1, 'h54, 0); step();
        drive(1, 'h58, 1, 0, 1, 'h5c, 1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        idle(4);

        // Lock, then master 0 drops its request: master 1 granted that cycle
        drive(1, 'h60, 0, 1, 1, 'h70, 0); step();
        drive(1, 'h64, 1, 1, 1, 'h70, 0); step();
        drive(0, 0, 0, 0, 1, 'h70, 0);    step();
        idle(3);

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            drive(w[1:0] != 0, 4 * int'(w[9:2]), w[10], w[12:11] == 0,
                  w[14:13] != 0, 4 * int'(w[22:15]), w[23]);
            reset = (w[31:25] != 0);
            step();
            reset = 1'b1;
        end
        idle(RD_LAT + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter that shares the single-port data RAM between the processor's memory-side bus port (master 0) and a secondary bus master such as a DMA or video fetch engine (master 1). It sits between the memory-side outputs of `system_bus` and `RAM`, grants at most one access per cycle, and returns read data to the issuing master after the RAM's fixed read latency. Master 0 has priority. A starvation counter bounds master 1's wait, and a lock input lets master 0 perform uninterrupted read-modify-write sequences.

## Interface

- `RD_LAT`, 1: RAM read latency in cycles, legal range 1–4.
- `STARVE_MAX`, 8: cycles master 1 may wait before a forced grant, legal range 1–255.

- `clock` input 1: the single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `m0_req`, `m1_req` input 1 each: access request.
- `m0_addr`, `m1_addr` input 32 each: byte address.
- `m0_read_type`, `m1_read_type` input 3 each: access size/sign code, passed through unchanged.
- `m0_write_data`, `m1_write_data` input 32 each: store data.
- `m0_write_en`, `m1_write_en` input 1 each: 1 means store, 0 means load.
- `m0_lock` input 1: hold the bus for master 0 after this access.
- `m0_gnt`, `m1_gnt` output 1 each: combinational grant.
- `m0_rvalid`, `m1_rvalid` output 1 each: load data valid this cycle.
- `m0_rdata`, `m1_rdata` output 32 each: both equal `memory_read_data`; meaningful only while the matching `rvalid` is high.
- `memory_addr` output 32, `memory_read_type` output 3, `memory_write_data` output 32, `memory_write_en` output 1: RAM-side request.
- `memory_read_data` input 32: RAM load data.

## Operation

- An access issues in a cycle where `mX_req` and `mX_gnt` are both 1. At most one grant is high per cycle.
- The RAM-side outputs are a combinational mux of the granted master's signals.
- `memory_write_en` is `req & gnt & write_en` of the granted master.
- With no grant, `memory_addr`, `memory_read_type` and `memory_write_data` are 0 and `memory_write_en` is 0.

State machine, two states:
- ARB (the reset state):
  - `m1_gnt = m1_req & (!m0_req | wait_cnt == STARVE_MAX)`.
  - `m0_gnt = m0_req & !m1_gnt`.
  - If master 0 issues with `m0_lock` = 1, go to LOCK0.
- LOCK0:
  - `m0_gnt = m0_req`; `m1_gnt = 0`.
  - Return to ARB after master 0 issues with `m0_lock` = 0, or in any cycle where `m0_req` = 0.
  - A lock held by master 0 overrides a saturated `wait_cnt`.

Starvation counter `wait_cnt`:
- Width is ceil(log2(STARVE_MAX+1)).
- Increments when `m1_req` = 1 and master 1 does not issue, saturating at STARVE_MAX.
- Clears to 0 when master 1 issues, or when `m1_req` = 0.

Read tracking:
- A shift register of depth RD_LAT. Each stage holds {valid, id}.
- Stage 0 loads {1, id} when a load issues, and {0, x} otherwise.
- When the last stage has valid = 1, that stage's id selects which `mX_rvalid` is high.
- Stores never produce an rvalid.
- Loads issued back-to-back by alternating masters return in issue order, one per cycle. No stall is ever needed.

Reset, asserted asynchronously:
- State returns to ARB.
- `wait_cnt` clears to 0.
- The whole shift register clears, so in-flight loads are dropped and no rvalid is produced for them.
- While `reset` = 0, both grants, both rvalids and `memory_write_en` are 0.

## Timing

- Grant is combinational from the current cycle's req, state and counter. There is no arbitration latency.
- A load issued in cycle N asserts `mX_rvalid` in cycle N+RD_LAT. Data is sampled in that same cycle.
- A store is committed by the RAM at the edge ending the issue cycle.
- The request signals of a master that is not granted must be held by that master. The arbiter has no request buffering.
- Throughput is one access per cycle, in any mix of masters.
- Simultaneous requests with `wait_cnt` < STARVE_MAX: master 0 wins and `wait_cnt` increments.

## Test plan

- Reset released; master 0 loads 0x100 then stores 0x104; master 1 idle. Expect `m0_gnt` = 1 both cycles, `memory_write_en` = 1 only in the store cycle, and `m0_rvalid` exactly RD_LAT cycles after the load with `m0_rdata` equal to the stored RAM word.
- Both masters request continuously with STARVE_MAX = 8. Expect the pattern of 8 master-0 grants then 1 master-1 grant to repeat, and `wait_cnt` to never exceed 8.
- Master 0 issues with `m0_lock` = 1 for 3 accesses, then `m0_lock` = 0, while master 1 requests throughout and `wait_cnt` is saturated. Expect no `m1_gnt` until the cycle after the unlocking access.
- Loads alternate m0, m1, m0 in consecutive cycles with RD_LAT = 2. Expect rvalid on m0, m1, m0 in cycles 2, 3, 4, each with the matching RAM data.
- `reset` is pulsed low while two loads are in flight. Expect grants, rvalids and `memory_write_en` to drop immediately, and no rvalid to appear after release.
- Master 0 drops `m0_req` while in LOCK0. Expect a return to ARB and master 1 granted in that same cycle.
